// File: rtl/cpu_alu_unit_if.sv
// cpu_alu_unit_if: operand/opcode/result bundle between the datapath temporaries and the ALU.
// Latency: none; this is wiring only.
// Backpressure: none; the ALU accepts a new operation on every clock edge.
//
// Signals:
//   oe      output enable for out (combinational in the ALU)
//   opcode  4-bit operation select
//   a, b    operands from T1 / T2
//   cin     carry/borrow in (ADC/SBB only)
//   out     result gated by oe
//   flags   {P,V,C,N,Z}, always driven
interface cpu_alu_unit_if #(
  parameter int WIDTH  = 16,
  parameter int FLAG_W = 5
);
  logic              oe;
  logic [3:0]        opcode;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic [WIDTH-1:0]  out;
  logic [FLAG_W-1:0] flags;

  // Datapath side: drives operands, observes result.
  modport master (
    output oe, opcode, a, b, cin,
    input  out, flags
  );

  // ALU side.
  modport slave (
    input  oe, opcode, a, b, cin,
    output out, flags
  );
endinterface

// File: rtl/cpu_alu_unit.sv
// cpu_alu_unit: 16-op registered ALU; result and {P,V,C,N,Z} flags latched every rising clk edge.
// Latency: one cycle from opcode/operands to out/flags; oe gates out combinationally.
// Backpressure: none; a new operation is accepted every cycle and there is no hold input.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-low reset (clears result and flags)
//   bus   cpu_alu_unit_if.slave: oe, opcode, a, b, cin in; out, flags out
//
// Optional build macro: ALU_MUL_EN
//   defined   -> opcode F is an unsigned multiply (low word result, C=V=upper word nonzero)
//   undefined -> opcode F passes b through; no multiplier is built
//
// WIDTH must match the WIDTH of the connected interface instance (minimum 4).
module cpu_alu_unit #(
  parameter int WIDTH  = 16,
  parameter int FLAG_W = 5
) (
  input logic           clk,
  input logic           rst,
  cpu_alu_unit_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SBB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_SAR = 4'hA;
  localparam logic [3:0] OP_ROL = 4'hB;
  localparam logic [3:0] OP_ROR = 4'hC;
  localparam logic [3:0] OP_INC = 4'hD;
  localparam logic [3:0] OP_DEC = 4'hE;
  localparam logic [3:0] OP_F   = 4'hF;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]  r_result;
  logic [FLAG_W-1:0] r_flags;

  // One WIDTH+1 adder/subtractor result each; bit WIDTH is carry (add) or borrow (sub).
  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_diff;
  logic              w_cin_add;
  logic              w_cin_sub;
  logic [WIDTH-1:0]  w_result;
  logic              w_c;
  logic              w_v;
  logic [FLAG_W-1:0] w_flags;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] w_prod;
  assign w_prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
`endif

  // cin only matters for ADC/SBB; plain ADD/SUB share the same adder with cin forced low.
  assign w_cin_add = (bus.opcode == OP_ADC) ? bus.cin : 1'b0;
  assign w_cin_sub = (bus.opcode == OP_SBB) ? bus.cin : 1'b0;

  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, w_cin_add};
  // Borrow is bit WIDTH: a < b+cin makes the WIDTH+1-bit difference wrap negative.
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, w_cin_sub};

  always_comb begin
    w_result = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (bus.opcode)
      OP_ADD, OP_ADC: begin
        w_result = w_sum[MSB:0];
        w_c      = w_sum[WIDTH];
        // Same-sign operands producing an opposite-sign result.
        w_v      = (bus.a[MSB] == bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
      end
      OP_SUB, OP_SBB: begin
        w_result = w_diff[MSB:0];
        w_c      = w_diff[WIDTH];
        // Opposite-sign operands where the result sign differs from a.
        w_v      = (bus.a[MSB] != bus.b[MSB]) && (w_diff[MSB] != bus.a[MSB]);
      end
      OP_AND: w_result = bus.a & bus.b;
      OP_OR:  w_result = bus.a | bus.b;
      OP_XOR: w_result = bus.a ^ bus.b;
      OP_NOT: w_result = ~bus.a;
      OP_SHL: begin
        w_result = {bus.a[MSB-1:0], 1'b0};
        w_c      = bus.a[MSB];
        w_v      = bus.a[MSB] ^ bus.a[MSB-1];
      end
      OP_SHR: begin
        w_result = {1'b0, bus.a[MSB:1]};
        w_c      = bus.a[0];
      end
      OP_SAR: begin
        w_result = {bus.a[MSB], bus.a[MSB:1]};
        w_c      = bus.a[0];
      end
      OP_ROL: begin
        w_result = {bus.a[MSB-1:0], bus.a[MSB]};
        w_c      = bus.a[MSB];
      end
      OP_ROR: begin
        w_result = {bus.a[0], bus.a[MSB:1]};
        w_c      = bus.a[0];
      end
      OP_INC: begin
        w_result = bus.a + 1'b1;
        w_c      = &bus.a;
        w_v      = (bus.a == MAX_POS);
      end
      OP_DEC: begin
        w_result = bus.a - 1'b1;
        w_c      = ~|bus.a;
        w_v      = (bus.a == MIN_NEG);
      end
      OP_F: begin
`ifdef ALU_MUL_EN
        w_result = w_prod[MSB:0];
        w_c      = |w_prod[2*WIDTH-1:WIDTH];
        w_v      = |w_prod[2*WIDTH-1:WIDTH];
`else
        w_result = bus.b;
`endif
      end
    endcase
  end

  // {P, V, C, N, Z}; P is set for an even number of ones.
  assign w_flags = {~^w_result, w_v, w_c, w_result[MSB], ~|w_result};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_result <= w_result;
      r_flags  <= w_flags;
    end
  end

  assign bus.out   = bus.oe ? r_result : '0;
  assign bus.flags = r_flags;

endmodule

// File: tb/tb_cpu_alu_unit.sv
module tb_cpu_alu_unit;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cpu_alu_unit_if #(.WIDTH(W), .FLAG_W(5)) bus ();

  cpu_alu_unit #(.WIDTH(W), .FLAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int unsigned u);
    return (u >= 32768) ? int'(u) - 65536 : int'(u);
  endfunction

  // Reference model in plain integer arithmetic; returns {flags, result}.
  function automatic logic [20:0] model(input logic [3:0] op, input int unsigned ua,
                                        input int unsigned ub, input int unsigned ci);
    int unsigned res = 0;
    longint      prod;
    int          s;
    logic        c = 1'b0;
    logic        v = 1'b0;
    logic [4:0]  f;
    logic [15:0] r16;
    case (op)
      4'h0, 4'h1: begin
        if (op == 4'h0) ci = 0;
        res = (ua + ub + ci) % 65536;
        c   = (ua + ub + ci) >= 65536;
        s   = to_signed(ua) + to_signed(ub) + int'(ci);
        v   = (s > 32767) || (s < -32768);
      end
      4'h2, 4'h3: begin
        if (op == 4'h2) ci = 0;
        res = (ua + 65536 * 2 - ub - ci) % 65536;
        c   = ua < (ub + ci);
        s   = to_signed(ua) - to_signed(ub) - int'(ci);
        v   = (s > 32767) || (s < -32768);
      end
      4'h4: res = ua & ub;
      4'h5: res = ua | ub;
      4'h6: res = ua ^ ub;
      4'h7: res = 65535 - ua;
      4'h8: begin
        res = (ua * 2) % 65536;
        c   = ua >= 32768;
        v   = (ua >= 32768) != (res >= 32768);
      end
      4'h9: begin res = ua / 2; c = ua % 2; end
      4'hA: begin res = ua / 2 + ((ua >= 32768) ? 32768 : 0); c = ua % 2; end
      4'hB: begin res = (ua * 2) % 65536 + ua / 32768; c = ua >= 32768; end
      4'hC: begin res = ua / 2 + (ua % 2) * 32768; c = ua % 2; end
      4'hD: begin res = (ua + 1) % 65536; c = ua == 65535; v = ua == 32767; end
      4'hE: begin res = (ua + 65535) % 65536; c = ua == 0; v = ua == 32768; end
      default: begin
`ifdef ALU_MUL_EN
        prod = longint'(ua) * longint'(ub);
        res  = int'(prod % 65536);
        c    = prod >= 65536;
        v    = c;
`else
        prod = 0;
        res  = ub;
`endif
      end
    endcase
    r16 = res[15:0];
    f = {($countones(r16) % 2) == 0, v, c, res >= 32768, res == 0};
    return {f, r16};
  endfunction

  // Apply one operation, clock it, then compare out/flags against the model.
  task automatic step(input string tag, input logic [3:0] op, input logic [15:0] av,
                      input logic [15:0] bv, input logic ci, input logic oe_v,
                      output logic [15:0] exp_res);
    logic [20:0] m;
    bus.opcode = op; bus.a = av; bus.b = bv; bus.cin = ci; bus.oe = oe_v;
    m = model(op, av, bv, ci);
    @(posedge clk);
    #1;
    exp_res = m[15:0];
    chk({tag, ".out"},   {16'h0, bus.out},   {16'h0, oe_v ? m[15:0] : 16'h0});
    chk({tag, ".flags"}, {27'h0, bus.flags}, {27'h0, m[20:16]});
  endtask

  logic [15:0] er;
  logic [4:0]  hold_flags;

  initial begin
    bus.oe = 1'b1; bus.opcode = 4'h0; bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0;

    // Reset asserted for one edge.
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.out",   {16'h0, bus.out},   32'h0);
    chk("rst.flags", {27'h0, bus.flags}, 32'h0);
    rst = 1'b1;
    step("rel", 4'h0, 16'h1234, 16'h1111, 1'b0, 1'b1, er);
    chk("rel.val", {16'h0, bus.out}, 32'h2345);

    step("add_c", 4'h0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, er);
    chk("add_c.raw", {16'h0, bus.out, 11'h0, bus.flags} , {16'h0000, 11'h0, 5'b10101});
    step("add_v", 4'h0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, er);
    chk("add_v.raw", {bus.out, 11'h0, bus.flags}, {16'h8000, 11'h0, 5'b01010});
    step("sub", 4'h2, 16'h0003, 16'h0005, 1'b0, 1'b1, er);
    chk("sub.raw", {bus.out, 11'h0, bus.flags}, {16'hFFFE, 11'h0, 5'b00110});
    step("sbb", 4'h3, 16'h0005, 16'h0003, 1'b1, 1'b1, er);
    chk("sbb.raw", {bus.out, 11'h0, bus.flags}, {16'h0001, 11'h0, 5'b00000});

    step("shr_oe0", 4'h9, 16'h0001, 16'hABCD, 1'b0, 1'b0, er);
    chk("shr.cz", {30'h0, bus.flags[2], bus.flags[0]}, 32'h3);
    bus.oe = 1'b1;
    #1;
    chk("shr.oe1", {16'h0, bus.out}, 32'h0);

    step("opf", 4'hF, 16'h0100, 16'h0100, 1'b0, 1'b1, er);
`ifdef ALU_MUL_EN
    chk("opf.raw", {bus.out, 27'h0, bus.flags[3:2]}, {16'h0000, 27'h0, 2'b11});
`else
    chk("opf.raw", {bus.out, 27'h0, bus.flags[3:2]}, {16'h0100, 27'h0, 2'b00});
`endif

    // Boundary operands on the single-operand ops.
    step("inc_max",  4'hD, 16'h7FFF, 16'h0, 1'b0, 1'b1, er);
    step("inc_ones", 4'hD, 16'hFFFF, 16'h0, 1'b0, 1'b1, er);
    step("dec_min",  4'hE, 16'h8000, 16'h0, 1'b0, 1'b1, er);
    step("dec_zero", 4'hE, 16'h0000, 16'h0, 1'b0, 1'b1, er);
    step("sar_neg",  4'hA, 16'h8001, 16'h0, 1'b0, 1'b1, er);
    step("rol_msb",  4'hB, 16'h8000, 16'h0, 1'b0, 1'b1, er);
    step("ror_lsb",  4'hC, 16'h0001, 16'h0, 1'b0, 1'b1, er);
    step("shl_v",    4'h8, 16'h4000, 16'h0, 1'b0, 1'b1, er);
    step("sbb_brw",  4'h3, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, er);

    // Randomized operations with oe toggling between edges and occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [15:0] av, bv;
      logic        ci, oev;
      op  = 4'($urandom_range(0, 15));
      av  = 16'($urandom);
      bv  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) av = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h8000;
      if ($urandom_range(0, 7) == 0) bv = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
      ci  = 1'($urandom_range(0, 1));
      oev = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        bus.opcode = op; bus.a = av; bus.b = bv; bus.cin = ci; bus.oe = 1'b1;
        @(posedge clk);
        #1;
        chk("rnd_rst", {11'h0, bus.flags, bus.out}, 32'h0);
        rst = 1'b1;
      end else begin
        step("rnd", op, av, bv, ci, oev, er);
        // Flipping oe must only gate out, never disturb the registered state.
        hold_flags = bus.flags;
        bus.oe = ~oev;
        #1;
        chk("rnd_oe.out",   {16'h0, bus.out},   {16'h0, (~oev) ? er : 16'h0});
        chk("rnd_oe.flags", {27'h0, bus.flags}, {27'h0, hold_flags});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
